// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================
// seg7_scan_if : counter-value in / display-pins out bundle
// Revision     : 1.0
// ============================================================
interface seg7_scan_if;
  logic [7:0] Data;
  logic       Mode;
  logic       Lzb;
  logic [6:0] Seg;
  logic [1:0] Dig;
  logic       Frame;

  modport master (output Data, Mode, Lzb, input  Seg, Dig, Frame);
  modport slave  (input  Data, Mode, Lzb, output Seg, Dig, Frame);
endinterface
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================
// seg7_scan : two-digit multiplexed 7-seg scanner, frame-latched
// Revision  : 1.0
// ============================================================
module seg7_scan #(
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16
) (
  input  wire logic  Clock,
  input  wire logic  Reset,
  seg7_scan_if.slave bus
);
  localparam int                 C_CNT_W      = $clog2(SCAN_DIV);
  localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'(BLANK_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_SHOW_LAST  = C_CNT_W'(SCAN_DIV - BLANK_CYC - 1);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         hi_q, hi_d, lo_q, lo_d;
  logic               md_q, md_d, lz_q, lz_d;
  logic               primed_q;
  logic [6:0]         seg_q, seg_d;
  logic [1:0]         dig_q, dig_d;
  logic               frame_q, frame_d;
  logic               w_last;
  logic               w_load;

  function automatic logic [6:0] glyph(input logic [3:0] n, input logic bcd);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    if (bcd && (n > 4'd9)) g = 7'h3F;
    return g;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + C_CNT_W'(1);
    hi_d    = hi_q;
    lo_d    = lo_q;
    md_d    = md_q;
    lz_d    = lz_q;
    w_load  = !primed_q;
    w_last  = ((state_q == BLANK0) || (state_q == BLANK1)) ? (cnt_q == C_BLANK_LAST)
                                                           : (cnt_q == C_SHOW_LAST);
    if (w_last) begin
      cnt_d = '0;
      case (state_q)
        BLANK0:  state_d = SHOW0;
        SHOW0:   state_d = BLANK1;
        BLANK1:  state_d = SHOW1;
        default: begin
          state_d = BLANK0;
          w_load  = 1'b1;
        end
      endcase
    end
    if (w_load) begin
      hi_d = bus.Data[7:4];
      lo_d = bus.Data[3:0];
      md_d = bus.Mode;
      lz_d = bus.Lzb;
    end
    // Outputs look at next-state/next-shadow so they switch on the same edge.
    seg_d   = 7'h7F;
    dig_d   = 2'b11;
    frame_d = w_load;
    if (state_d == SHOW0) begin
      seg_d = glyph(lo_d, md_d);
      dig_d = 2'b10;
    end else if ((state_d == SHOW1) && !(lz_d && (hi_d == 4'h0))) begin
      seg_d = glyph(hi_d, md_d);
      dig_d = 2'b01;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= BLANK0;
      cnt_q    <= '0;
      hi_q     <= 4'h0;
      lo_q     <= 4'h0;
      md_q     <= 1'b0;
      lz_q     <= 1'b0;
      primed_q <= 1'b0;
      seg_q    <= 7'h7F;
      dig_q    <= 2'b11;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      md_q     <= md_d;
      lz_q     <= lz_d;
      primed_q <= 1'b1;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.Seg   = seg_q;
  assign bus.Dig   = dig_q;
  assign bus.Frame = frame_q;
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================
// tb_seg7_scan : self-checking bench for seg7_scan (8/2 timing)
// Revision     : 1.0
// ============================================================
module tb_seg7_scan;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 2 * SD;

  logic Clock;
  logic Reset;
  seg7_scan_if bus ();

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic       mode;
    logic       lzb;
    logic [6:0] lo_seg;
    logic [6:0] hi_seg;
    logic [1:0] hi_dig;
  } vec_t;

  logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;
  int k     = 0;   // rising edges since reset release; frame position = k % FR
  logic [3:0] sh_hi, sh_lo;
  logic       sh_md, sh_lz;
  logic [1:0] last_lit;
  int         dark_run;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n, input logic bcd);
    if (bcd && n > 4'd9) return 7'h3F;
    return GL[n];
  endfunction

  // Expected outputs from position in the frame and the latched sample.
  task automatic ref_out(output logic [6:0] s, output logic [1:0] d, output logic f);
    int p;
    p = k % FR;
    f = (k == 1) || (k > 0 && p == 0);
    s = 7'h7F;
    d = 2'b11;
    if (p >= BC && p < SD) begin
      s = ref_glyph(sh_lo, sh_md);
      d = 2'b10;
    end else if (p >= SD + BC && !(sh_lz && sh_hi == 4'h0)) begin
      s = ref_glyph(sh_hi, sh_md);
      d = 2'b01;
    end
  endtask

  task automatic tick();
    logic [6:0] es;
    logic [1:0] ed;
    logic       ef;
    @(posedge Clock);
    k++;
    if (k == 1 || k % FR == 0) begin
      sh_hi = bus.Data[7:4];
      sh_lo = bus.Data[3:0];
      sh_md = bus.Mode;
      sh_lz = bus.Lzb;
    end
    @(negedge Clock);
    ref_out(es, ed, ef);
    check("model", {22'd0, bus.Seg, bus.Dig, bus.Frame}, {22'd0, es, ed, ef});
    if (bus.Dig == 2'b11) begin
      dark_run++;
    end else begin
      if (last_lit != 2'b00 && bus.Dig != last_lit) check("ghost", (dark_run >= BC) ? 1 : 0, 1);
      last_lit = bus.Dig;
      dark_run = 0;
    end
  endtask

  task automatic run_to_pos(input int p);
    int guard;
    guard = 0;
    tick();
    while ((k % FR) != p && guard < 2 * FR) begin
      tick();
      guard++;
    end
    if (guard >= 2 * FR) check("pos_timeout", guard, 0);
  endtask

  task automatic set_in(input logic [7:0] d, input logic m, input logic l);
    bus.Data = d;
    bus.Mode = m;
    bus.Lzb  = l;
  endtask

  task automatic release_reset();
    Reset    = 1'b1;
    k        = 0;
    last_lit = 2'b00;
    dark_run = 0;
  endtask

  task automatic scen_first();
    int f1, f2, guard;
    tick();
    check("frame1", int'(bus.Frame), 1);
    check("dig1", int'(bus.Dig), 2'b11);
    for (int e = 2; e <= 7; e++) begin
      tick();
      check("show0_dig", int'(bus.Dig), 2'b10);
      check("show0_seg", int'(bus.Seg), 7'h78);
    end
    tick();
    tick();
    for (int e = 10; e <= 15; e++) begin
      tick();
      check("show1_dig", int'(bus.Dig), 2'b01);
      check("show1_seg", int'(bus.Seg), 7'h30);
    end
    f1 = -1;
    f2 = -1;
    guard = 0;
    while (f2 < 0 && guard < 3 * FR) begin
      tick();
      guard++;
      if (bus.Frame) begin
        if (f1 < 0) f1 = k;
        else f2 = k;
      end
    end
    check("frame_edge", f1, FR);
    check("frame_period", f2 - f1, FR);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h37, 1'b0, 1'b0, 7'h78, 7'h30, 2'b01};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 7'h12, 7'h3F, 2'b01};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 7'h12, 7'h08, 2'b01};
    vecs[3] = '{8'h04, 1'b0, 1'b1, 7'h19, 7'h7F, 2'b11};
    vecs[4] = '{8'h04, 1'b0, 1'b0, 7'h19, 7'h40, 2'b01};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 7'h3F, 7'h3F, 2'b01};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 7'h40, 7'h7F, 2'b11};
    vecs[7] = '{8'hF0, 1'b0, 1'b0, 7'h40, 7'h0E, 2'b01};
    vecs[8] = '{8'h99, 1'b1, 1'b0, 7'h10, 7'h10, 2'b01};
    vecs[9] = '{8'h3C, 1'b1, 1'b0, 7'h3F, 7'h30, 2'b01};

    sh_hi = 4'h0; sh_lo = 4'h0; sh_md = 1'b0; sh_lz = 1'b0;
    last_lit = 2'b00;
    dark_run = 0;
    Reset = 1'b0;
    set_in(8'h37, 1'b0, 1'b0);
    repeat (3) @(negedge Clock);
    check("rst_seg", int'(bus.Seg), 7'h7F);
    check("rst_dig", int'(bus.Dig), 2'b11);
    check("rst_frame", int'(bus.Frame), 0);
    release_reset();
    scen_first();

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].data, vecs[i].mode, vecs[i].lzb);
      run_to_pos(0);
      run_to_pos(BC + 2);
      check("vec_lo_dig", int'(bus.Dig), 2'b10);
      check("vec_lo_seg", int'(bus.Seg), int'(vecs[i].lo_seg));
      run_to_pos(SD + BC + 2);
      check("vec_hi_dig", int'(bus.Dig), int'(vecs[i].hi_dig));
      check("vec_hi_seg", int'(bus.Seg), int'(vecs[i].hi_seg));
    end

    // No tearing: new data arrives mid-frame and must wait for the next load.
    set_in(8'h12, 1'b0, 1'b0);
    run_to_pos(0);
    run_to_pos(BC + 1);
    check("tear_lo_old", int'(bus.Seg), 7'h24);
    set_in(8'h89, 1'b0, 1'b0);
    run_to_pos(BC + 3);
    check("tear_lo_hold", int'(bus.Seg), 7'h24);
    run_to_pos(SD + BC + 1);
    check("tear_hi_old", int'(bus.Seg), 7'h79);
    run_to_pos(BC + 1);
    check("tear_lo_new", int'(bus.Seg), 7'h10);
    run_to_pos(SD + BC + 1);
    check("tear_hi_new", int'(bus.Seg), 7'h00);

    // Asynchronous reset between edges while a digit is lit.
    set_in(8'h37, 1'b0, 1'b0);
    run_to_pos(SD + BC + 2);
    #2;
    Reset = 1'b0;
    #1;
    check("arst_seg", int'(bus.Seg), 7'h7F);
    check("arst_dig", int'(bus.Dig), 2'b11);
    check("arst_frame", int'(bus.Frame), 0);
    repeat (2) @(negedge Clock);
    check("arst_hold_dig", int'(bus.Dig), 2'b11);
    release_reset();
    scen_first();

    // Random inputs every cycle, checked against the position model.
    for (int i = 0; i < 1100; i++) begin
      set_in(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
